// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor arbiter: op codes, coprocessor
// select map, sequencer states and select-lookup helpers.
package coproc_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_DIV = 2'd1,
    OP_SHF = 2'd2,
    OP_INV = 2'd3
  } op_e;

  localparam logic [10:0] SEL_BUSY = 11'h000;
  localparam logic [10:0] SEL_STAT = 11'h001;
  localparam logic [10:0] SEL_PHI  = 11'h002;
  localparam logic [10:0] SEL_PLO  = 11'h003;
  localparam logic [10:0] SEL_QUOT = 11'h004;
  localparam logic [10:0] SEL_REM  = 11'h005;
  localparam logic [10:0] SEL_SHI  = 11'h006;
  localparam logic [10:0] SEL_SLO  = 11'h007;
  localparam logic [10:0] SEL_MUL  = 11'h008;
  localparam logic [10:0] SEL_DIV  = 11'h009;
  localparam logic [10:0] SEL_SHF  = 11'h00A;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    POLL,
    PCHK,
    RD_HI,
    RD_LO,
    RD_X,
    FIN
  } state_e;

  // Shift commands carry the format in sel[7:6].
  function automatic logic [10:0] issue_sel(input op_e op, input logic [1:0] fmt);
    case (op)
      OP_MUL:  return SEL_MUL;
      OP_DIV:  return SEL_DIV;
      default: return {3'b000, fmt, 2'b00, SEL_SHF[3:0]};
    endcase
  endfunction

  function automatic logic [10:0] rd_hi_sel(input op_e op);
    case (op)
      OP_MUL:  return SEL_PHI;
      OP_DIV:  return SEL_QUOT;
      default: return SEL_SHI;
    endcase
  endfunction

  function automatic logic [10:0] rd_lo_sel(input op_e op);
    case (op)
      OP_MUL:  return SEL_PLO;
      OP_DIV:  return SEL_REM;
      default: return SEL_SLO;
    endcase
  endfunction

endpackage

// File: rtl/coproc_arbiter_if.sv
// Requester and coprocessor signals of the arbiter. The slave modport is the
// arbiter's view; master is the requesters/coprocessor side.
interface coproc_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [1:0]         req;
  logic [3:0]         op;
  logic [3:0]         fmt;
  logic [2*WIDTH-1:0] a;
  logic [2*WIDTH-1:0] b;
  logic [2*WIDTH-1:0] c;
  logic [1:0]         done;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_ovf;
  logic [10:0]        cp_sel;
  logic               cp_go;
  logic [WIDTH-1:0]   cp_a;
  logic [WIDTH-1:0]   cp_b;
  logic [WIDTH-1:0]   cp_c;
  logic [WIDTH-1:0]   cp_y;

  modport slave (
    input  req, op, fmt, a, b, c, cp_y,
    output done, res_hi, res_lo, res_ovf, cp_sel, cp_go, cp_a, cp_b, cp_c
  );

  modport master (
    output req, op, fmt, a, b, c, cp_y,
    input  done, res_hi, res_lo, res_ovf, cp_sel, cp_go, cp_a, cp_b, cp_c
  );
endinterface

// File: rtl/coproc_arb_grant.sv
// Two-way grant selection. COPROC_ARB_RR_EN selects round-robin with a
// last-granted pointer; otherwise port 0 has fixed priority.
module coproc_arb_grant (
`ifdef COPROC_ARB_RR_EN
  input  logic       clk,
  input  logic       arstn,
`endif
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] done,
  output logic       gnt_vld,
  output logic       gnt_port
);

  logic [1:0] elig;

  always_comb begin
    elig = req & ~done;
  end

`ifdef COPROC_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)
      last_q <= 1'b1;
    else if (gnt_vld)
      last_q <= gnt_port;
  end

  always_comb begin
    gnt_vld  = en & (|elig);
    gnt_port = (elig == 2'b11) ? ~last_q : elig[1];
  end
`else
  // Port 1 waits while req[0] is high, even in port 0's done cycle.
  always_comb begin
    gnt_vld  = en & (elig[0] | (elig[1] & ~req[0]));
    gnt_port = ~elig[0];
  end
`endif

endmodule

// File: rtl/coproc_arbiter.sv
// Shares the mul/div/shift coprocessor between two requesters: grant, issue,
// poll busy, read back results, pulse done. Build option: COPROC_ARB_RR_EN.
module coproc_arbiter
  import coproc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            arstn,
  coproc_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic             port_q;
  op_e              op_q;
  logic [1:0]       fmt_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [WIDTH-1:0] res_hi_q, res_lo_q;
  logic             res_ovf_q;
  logic [1:0]       done_q;
  logic             gnt_vld, gnt_port;
  op_e              gnt_op;
  logic [10:0]      sel;
  logic             go;

  coproc_arb_grant u_grant (
`ifdef COPROC_ARB_RR_EN
    .clk      (clk),
    .arstn    (arstn),
`endif
    .en       (state_q == IDLE),
    .req      (bus.req),
    .done     (done_q),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  always_comb begin
    gnt_op = op_e'(gnt_port ? bus.op[3:2] : bus.op[1:0]);
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    sel     = SEL_BUSY;
    case (state_q)
      IDLE: begin
        if (gnt_vld)
          state_d = (gnt_op == OP_INV) ? FIN : ISSUE;
      end
      ISSUE: begin
        go      = 1'b1;
        sel     = issue_sel(op_q, fmt_q);
        state_d = POLL;
      end
      POLL: begin
        go      = 1'b1;
        sel     = SEL_BUSY;
        state_d = PCHK;
      end
      PCHK: begin
        state_d = bus.cp_y[0] ? POLL : RD_HI;
      end
      RD_HI: begin
        go      = 1'b1;
        sel     = rd_hi_sel(op_q);
        state_d = RD_LO;
      end
      RD_LO: begin
        go      = 1'b1;
        sel     = rd_lo_sel(op_q);
        state_d = RD_X;
      end
      RD_X: begin
        if (op_q == OP_DIV) begin
          go  = 1'b1;
          sel = SEL_STAT;
        end
        state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      port_q    <= 1'b0;
      op_q      <= OP_MUL;
      fmt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      res_ovf_q <= 1'b0;
      done_q    <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            port_q <= gnt_port;
            op_q   <= gnt_op;
            fmt_q  <= gnt_port ? bus.fmt[3:2] : bus.fmt[1:0];
            a_q    <= gnt_port ? bus.a[2*WIDTH-1:WIDTH] : bus.a[WIDTH-1:0];
            b_q    <= gnt_port ? bus.b[2*WIDTH-1:WIDTH] : bus.b[WIDTH-1:0];
            c_q    <= gnt_port ? bus.c[2*WIDTH-1:WIDTH] : bus.c[WIDTH-1:0];
          end
        end
        RD_LO: res_hi_q <= bus.cp_y;
        RD_X:  res_lo_q <= bus.cp_y;
        FIN: begin
          if (op_q == OP_INV) begin
            res_hi_q <= '0;
            res_lo_q <= '0;
          end
          res_ovf_q      <= (op_q == OP_DIV) ? bus.cp_y[8] : 1'b0;
          done_q[port_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.done    = done_q;
    bus.res_hi  = res_hi_q;
    bus.res_lo  = res_lo_q;
    bus.res_ovf = res_ovf_q;
    bus.cp_sel  = sel;
    bus.cp_go   = go;
    bus.cp_a    = a_q;
    bus.cp_b    = b_q;
    bus.cp_c    = c_q;
  end

endmodule

// File: tb/tb_coproc_arbiter.sv
// Directed bench for coproc_arbiter with a behavioural coprocessor model;
// expectations follow COPROC_ARB_RR_EN when it is defined.
`timescale 1ns/1ps
module tb_coproc_arbiter;
  import coproc_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  coproc_arbiter_if #(.WIDTH(W)) bus ();
  coproc_arbiter #(.WIDTH(W)) dut (.clk(clk), .arstn(arstn), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Coprocessor model
  int unsigned      busy_cfg = 0;
  int unsigned      m_busy;
  logic [W-1:0]     m_phi, m_plo, m_quot, m_rem, m_shi, m_slo;
  logic             m_ovf;
  logic [10:0]      sel_log [256];
  int unsigned      log_n = 0;
  int unsigned      viol  = 0;

  function automatic logic [31:0] shf(input logic [1:0] f, input logic [31:0] v, input logic [4:0] n);
    case (f)
      2'd0:    return v << n;
      2'd1:    return v >> n;
      2'd2:    return $signed(v) >>> n;
      default: return (v << n) | (v >> (6'd32 - {1'b0, n}));
    endcase
  endfunction

  function automatic logic [32:0] divm(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [W-1:0] d);
    logic [31:0] dd;
    dd = {hi, lo};
    if (d == '0 || hi >= d) return {1'b1, 16'hFFFF, 16'h0000};
    return {1'b0, 16'(dd / {16'h0, d}), 16'(dd % {16'h0, d})};
  endfunction

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      bus.cp_y <= '0;
      m_busy   <= 0;
      m_ovf    <= 1'b0;
    end else begin
      if (bus.cp_sel[10:8] != 3'b000) viol <= viol + 1;
      if (bus.cp_sel[7:6] != 2'b00 && !(bus.cp_go && bus.cp_sel[3:0] == 4'hA)) viol <= viol + 1;
      if (bus.cp_go) begin
        sel_log[log_n[7:0]] <= bus.cp_sel;
        log_n <= log_n + 1;
        if (bus.cp_sel[3:0] == 4'hA && bus.cp_sel[5:4] == 2'b00) begin
          {m_shi, m_slo} <= shf(bus.cp_sel[7:6], {bus.cp_a, bus.cp_b}, bus.cp_c[4:0]);
          m_busy <= busy_cfg;
        end else begin
          case (bus.cp_sel)
            SEL_MUL: begin
              {m_phi, m_plo} <= {16'h0, bus.cp_a} * {16'h0, bus.cp_b};
              m_busy <= busy_cfg;
            end
            SEL_DIV: begin
              {m_ovf, m_quot, m_rem} <= divm(bus.cp_a, bus.cp_b, bus.cp_c);
              m_busy <= busy_cfg;
            end
            SEL_BUSY: begin
              bus.cp_y <= {15'h0, m_busy != 0};
              if (m_busy != 0) m_busy <= m_busy - 1;
            end
            SEL_STAT: bus.cp_y <= {7'h0, m_ovf, 8'h0};
            SEL_PHI:  bus.cp_y <= m_phi;
            SEL_PLO:  bus.cp_y <= m_plo;
            SEL_QUOT: bus.cp_y <= m_quot;
            SEL_REM:  bus.cp_y <= m_rem;
            SEL_SHI:  bus.cp_y <= m_shi;
            SEL_SLO:  bus.cp_y <= m_slo;
            default:  viol <= viol + 1;
          endcase
        end
      end
    end
  end

  typedef struct {
    int unsigned port;
    logic [1:0]  op;
    logic [1:0]  fmt;
    logic [15:0] a, b, c;
    int unsigned busy;
    logic [10:0] issue;
    logic [15:0] hi, lo;
    logic        ovf;
    int unsigned lat;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int unsigned  cyc = 0;
    int unsigned  l0;
    int unsigned  ngo;
    logic [1:0]   dn = '0;
    logic [10:0]  exp_seq[$];
    @(posedge clk); #1;
    busy_cfg = v.busy;
    if (v.port == 0) begin
      bus.op[1:0] = v.op; bus.fmt[1:0] = v.fmt;
      bus.a[15:0] = v.a;  bus.b[15:0] = v.b;  bus.c[15:0] = v.c;
    end else begin
      bus.op[3:2] = v.op; bus.fmt[3:2] = v.fmt;
      bus.a[31:16] = v.a; bus.b[31:16] = v.b; bus.c[31:16] = v.c;
    end
    bus.req[v.port] = 1'b1;
    l0 = log_n;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      dn = bus.done;
      if (dn != 2'b00) break;
    end
    bus.req[v.port] = 1'b0;
    check({tag, ".done"}, dn, 2'b01 << v.port);
    check({tag, ".lat"}, cyc, v.lat);
    check({tag, ".hi"}, bus.res_hi, v.hi);
    check({tag, ".lo"}, bus.res_lo, v.lo);
    check({tag, ".ovf"}, bus.res_ovf, v.ovf);
    if (v.op != 2'd3) begin
      exp_seq.push_back(v.issue);
      for (int i = 0; i <= int'(v.busy); i++) exp_seq.push_back(SEL_BUSY);
      case (v.op)
        2'd0:    begin exp_seq.push_back(SEL_PHI);  exp_seq.push_back(SEL_PLO); end
        2'd1:    begin exp_seq.push_back(SEL_QUOT); exp_seq.push_back(SEL_REM); exp_seq.push_back(SEL_STAT); end
        default: begin exp_seq.push_back(SEL_SHI);  exp_seq.push_back(SEL_SLO); end
      endcase
    end
    ngo = log_n - l0;
    check({tag, ".gos"}, ngo, exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < int'(ngo); i++)
      check($sformatf("%s.sel%0d", tag, i), sel_log[8'(l0 + i)], exp_seq[i]);
    @(posedge clk); #1;
    check({tag, ".pulse"}, bus.done, 2'b00);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".done"}, bus.done, 2'b00);
    check({tag, ".res"}, {bus.res_hi, bus.res_lo}, 32'h0);
    check({tag, ".ovf"}, bus.res_ovf, 1'b0);
    check({tag, ".cpcmd"}, {20'h0, bus.cp_go, bus.cp_sel}, 32'h0);
    check({tag, ".cpab"}, {bus.cp_a, bus.cp_b}, 32'h0);
    check({tag, ".cpc"}, bus.cp_c, 16'h0);
  endtask

  vec_t vecs[9];

  initial begin
    int unsigned cyc;
    int unsigned ndone;
    logic [1:0]  dn;
    int unsigned exp_p;

    vecs[0] = '{0, 2'd0, 2'd0, 16'h1234, 16'h5678, 16'h0000, 0, 11'h008, 16'h0626, 16'h0060, 1'b0, 8};
    vecs[1] = '{1, 2'd1, 2'd0, 16'h0000, 16'h0064, 16'h0007, 0, 11'h009, 16'h000E, 16'h0002, 1'b0, 8};
    vecs[2] = '{1, 2'd1, 2'd0, 16'h0010, 16'h0000, 16'h0001, 1, 11'h009, 16'hFFFF, 16'h0000, 1'b1, 10};
    vecs[3] = '{0, 2'd2, 2'd2, 16'h8001, 16'h0000, 16'h0004, 2, 11'h08A, 16'hF800, 16'h1000, 1'b0, 12};
    vecs[4] = '{0, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 11'h008, 16'hFFFE, 16'h0001, 1'b0, 10};
    vecs[5] = '{1, 2'd3, 2'd0, 16'h1111, 16'h2222, 16'h3333, 0, 11'h000, 16'h0000, 16'h0000, 1'b0, 2};
    vecs[6] = '{0, 2'd2, 2'd0, 16'h0001, 16'h8000, 16'h0001, 0, 11'h00A, 16'h0003, 16'h0000, 1'b0, 8};
    vecs[7] = '{1, 2'd2, 2'd1, 16'h8000, 16'h0001, 16'h0010, 0, 11'h04A, 16'h0000, 16'h8000, 1'b0, 8};
    vecs[8] = '{0, 2'd2, 2'd3, 16'h8000, 16'h0001, 16'h0004, 0, 11'h0CA, 16'h0000, 16'h0018, 1'b0, 8};

    bus.req = '0; bus.op = '0; bus.fmt = '0; bus.a = '0; bus.b = '0; bus.c = '0;
    arstn = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) arstn = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Reset while the sequencer is polling a long-busy multiply
    @(posedge clk); #1;
    busy_cfg = 6;
    bus.op[1:0] = 2'd0; bus.a[15:0] = 16'h0003; bus.b[15:0] = 16'h0005; bus.c[15:0] = 16'h0009;
    bus.req[0] = 1'b1;
    cyc = 0;
    while (cyc < 20 && !(bus.cp_go && bus.cp_sel == SEL_BUSY)) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst.poll_seen", {bus.cp_go, bus.cp_sel}, {1'b1, SEL_BUSY});
    #2 arstn = 1'b0;
    bus.req = '0;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk) arstn = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done != 2'b00) ndone++;
    end
    check("rst_mid.nodone", ndone, 0);
    run_txn('{0, 2'd0, 2'd0, 16'h0003, 16'h0005, 16'h0000, 0, 11'h008, 16'h0000, 16'h000F, 1'b0, 8}, "after_rst");

    // Contention: both ports hold req high continuously
    arstn = 1'b0;
    #3 arstn = 1'b1;
    busy_cfg = 0;
    @(posedge clk); #1;
    bus.op = 4'b0000;
    bus.a = {16'd4, 16'd2}; bus.b = {16'd5, 16'd3}; bus.c = '0;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      dn = '0;
      while (cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        dn = bus.done;
        if (dn != 2'b00) break;
      end
`ifdef COPROC_ARB_RR_EN
      exp_p = k % 2;
`else
      exp_p = 0;
`endif
      check($sformatf("cont.grant%0d", k), dn, 2'b01 << exp_p);
      check($sformatf("cont.lo%0d", k), bus.res_lo, (exp_p == 1) ? 16'd20 : 16'd6);
    end
    bus.req = '0;
    repeat (30) @(posedge clk);
    #1;
    check("cpsel_rules", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
